execute_branch_jump: RTL and testbench

Parametrised control-transfer execute unit: resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR, computes the target, writes the link value and flags misaligned targets. It sits in the execute stage beside the other execute units and shares the common ALU for comparisons and, optionally, for target addition. It also keeps saturating branch/taken counters for performance monitoring.

---
 rtl/execute_branch_jump_if.sv | 56 +++++
 rtl/execute_branch_jump.sv | 165 ++++++++++++++++
 tb/tb_execute_branch_jump.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_branch_jump_if.sv
// Bundle of decode/operand inputs, shared-ALU handshake, completion outputs and perf counters
// for the branch/jump execute unit. The unit uses the slave view; its environment uses master.
interface execute_branch_jump_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 flush;
    logic [6:0]           decode_opcode;
    logic [2:0]           decode_funct3;
    logic [XLEN-1:0]      decode_imm;
    logic [XLEN-1:0]      decode_pc;
    logic [XLEN-1:0]      read_rs1_val;
    logic [XLEN-1:0]      read_rs2_val;
    logic                 read_valid;
    logic [XLEN:0]        in_a;
    logic [XLEN:0]        in_b;
    logic [4:0]           alu_op;
    logic                 alu_valid;
    logic [XLEN-1:0]      alu_result;
    logic                 alu_lt;
    logic                 alu_ltu;
    logic                 alu_eq;
    logic                 processing;
    logic                 valid;
    logic [XLEN-1:0]      pc_out;
    logic                 jump_pc;
    logic [XLEN-1:0]      rd_val;
    logic                 rd_write;
    logic [5:0]           exception_num_out;
    logic                 exception_valid_out;
    logic                 cnt_clear;
    logic [CNT_WIDTH-1:0] cnt_branches;
    logic [CNT_WIDTH-1:0] cnt_taken;

    modport slave (
        input  flush, decode_opcode, decode_funct3, decode_imm, decode_pc,
        input  read_rs1_val, read_rs2_val, read_valid,
        output in_a, in_b, alu_op, alu_valid,
        input  alu_result, alu_lt, alu_ltu, alu_eq,
        output processing, valid, pc_out, jump_pc, rd_val, rd_write,
        output exception_num_out, exception_valid_out,
        input  cnt_clear,
        output cnt_branches, cnt_taken
    );

    modport master (
        output flush, decode_opcode, decode_funct3, decode_imm, decode_pc,
        output read_rs1_val, read_rs2_val, read_valid,
        input  in_a, in_b, alu_op, alu_valid,
        output alu_result, alu_lt, alu_ltu, alu_eq,
        input  processing, valid, pc_out, jump_pc, rd_val, rd_write,
        input  exception_num_out, exception_valid_out,
        output cnt_clear,
        input  cnt_branches, cnt_taken
    );
endinterface

// File: rtl/execute_branch_jump.sv
// Control-transfer execute unit: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR using the
// shared ALU, produces target/link values, flags misaligned targets and counts branches.
module execute_branch_jump #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned IALIGN      = 32,
    parameter int unsigned LOCAL_ADDER = 0,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input logic                  clk,
    input logic                  reset,
    execute_branch_jump_if.slave bus
);
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [4:0] AluAdd     = 5'd0;
    localparam logic [4:0] AluSub     = 5'd1;
    localparam logic [4:0] AluSlt     = 5'd2;
    localparam logic [4:0] AluSltu    = 5'd3;
    localparam logic [4:0] AluUnknown = 5'd8;
    localparam logic [XLEN-1:0] ClearBit0 = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [0:0] {StCheck, StTarget} state_e;

    state_e               state_q, state_d;
    logic                 is_branch, is_jal, is_jalr, known, take, kill;
    logic [XLEN-1:0]      local_sum, jalr_sum, link, target;
    logic                 complete, taken_req, link_req, branch_req, misaligned;
    logic [CNT_WIDTH-1:0] cnt_branches_q, cnt_branches_d, cnt_taken_q, cnt_taken_d;

    // Private adders: only the link incrementer is always used; the target adders matter
    // when LOCAL_ADDER is set.
    assign local_sum = bus.decode_pc + bus.decode_imm;
    assign jalr_sum  = (bus.read_rs1_val + bus.decode_imm) & ClearBit0;
    assign link      = bus.decode_pc + XLEN'(4);

    // Instruction decode: funct3 2 and 3 are not branches.
    always_comb begin
        is_branch = (bus.decode_opcode == OpBranch) && (bus.decode_funct3[2:1] != 2'b01);
        is_jal    = (bus.decode_opcode == OpJal);
        is_jalr   = (bus.decode_opcode == OpJalr) && (bus.decode_funct3 == 3'd0);
        known     = is_branch || is_jal || is_jalr;
    end

    // Branch condition from the ALU compare flags.
    always_comb begin
        take = 1'b0;
        case (bus.decode_funct3)
            3'd0:    take = bus.alu_eq;
            3'd1:    take = !bus.alu_eq;
            3'd4:    take = bus.alu_lt;
            3'd5:    take = !bus.alu_lt || bus.alu_eq;
            3'd6:    take = bus.alu_ltu;
            3'd7:    take = !bus.alu_ltu || bus.alu_eq;
            default: take = 1'b0;
        endcase
    end

    // Next-state, ALU request and completion outputs.
    always_comb begin
        state_d        = state_q;
        kill           = bus.flush || reset;
        bus.processing = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.alu_op     = AluUnknown;
        bus.in_a       = '0;
        bus.in_b       = '0;
        complete       = 1'b0;
        taken_req      = 1'b0;
        link_req       = 1'b0;
        branch_req     = 1'b0;
        target         = '0;
        unique case (state_q)
            StTarget: begin
                // Second cycle of a taken branch: the ALU is free again for pc+imm.
                bus.processing = 1'b1;
                bus.alu_valid  = 1'b1;
                bus.alu_op     = AluAdd;
                bus.in_a       = {1'b0, bus.decode_pc};
                bus.in_b       = {1'b0, bus.decode_imm};
                target         = bus.alu_result;
                complete       = 1'b1;
                taken_req      = 1'b1;
                branch_req     = 1'b1;
                state_d        = StCheck;
            end
            StCheck: begin
                if (bus.read_valid && known) begin
                    bus.processing = 1'b1;
                    if (is_branch) begin
                        bus.alu_valid = 1'b1;
                        bus.alu_op    = bus.decode_funct3[2] ?
                                        (bus.decode_funct3[1] ? AluSltu : AluSlt) : AluSub;
                        bus.in_a      = {1'b0, bus.read_rs1_val};
                        bus.in_b      = {1'b0, bus.read_rs2_val};
                        if (!take) begin
                            complete   = 1'b1;
                            branch_req = 1'b1;
                        end else if (LOCAL_ADDER != 0) begin
                            target     = local_sum;
                            complete   = 1'b1;
                            taken_req  = 1'b1;
                            branch_req = 1'b1;
                        end else if (!kill) begin
                            state_d = StTarget;
                        end
                    end else begin
                        complete  = 1'b1;
                        taken_req = 1'b1;
                        link_req  = 1'b1;
                        if (LOCAL_ADDER != 0) begin
                            target = is_jal ? local_sum : jalr_sum;
                        end else begin
                            bus.alu_valid = 1'b1;
                            bus.alu_op    = AluAdd;
                            bus.in_a      = {1'b0, is_jal ? bus.decode_pc : bus.read_rs1_val};
                            bus.in_b      = {1'b0, bus.decode_imm};
                            target        = is_jal ? bus.alu_result
                                                   : (bus.alu_result & ClearBit0);
                        end
                    end
                end
            end
            default: state_d = StCheck;
        endcase

        misaligned              = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);
        bus.valid               = complete && !kill;
        bus.jump_pc             = bus.valid && taken_req && !misaligned;
        bus.exception_valid_out = bus.valid && taken_req && misaligned;
        bus.rd_write            = bus.valid && link_req && !misaligned;
        bus.rd_val              = link_req ? link : '0;
        bus.pc_out              = taken_req ? target : '0;
        bus.exception_num_out   = '0;
    end

    // Saturating perf counters; clear wins over a simultaneous increment.
    always_comb begin
        cnt_branches_d = cnt_branches_q;
        cnt_taken_d    = cnt_taken_q;
        if (bus.cnt_clear) begin
            cnt_branches_d = '0;
            cnt_taken_d    = '0;
        end else if (bus.valid && branch_req) begin
            if (cnt_branches_q != '1) cnt_branches_d = cnt_branches_q + CNT_WIDTH'(1);
            if (bus.jump_pc && cnt_taken_q != '1) cnt_taken_d = cnt_taken_q + CNT_WIDTH'(1);
        end
    end

    // State and counter registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StCheck;
            cnt_branches_q <= '0;
            cnt_taken_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_branches_q <= cnt_branches_d;
            cnt_taken_q    <= cnt_taken_d;
        end
    end

    assign bus.cnt_branches = cnt_branches_q;
    assign bus.cnt_taken    = cnt_taken_q;
endmodule

// File: tb/tb_execute_branch_jump.sv
// Bench for execute_branch_jump: three instances (shared-ALU default, private adder with
// IALIGN=16, 2-bit counters) fed identical stimulus, each with a behavioural ALU.
module tb_execute_branch_jump;
    localparam logic [6:0] OpBr = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef struct {
        logic jump, exc, rdw, pc_chk, rd_chk;
        logic [31:0] pco, rdv;
        int lat;
    } exp_t;

    typedef struct {
        logic v, jp, rw, ex, pr, av, ext;
        logic [5:0] en;
        logic [31:0] pco, rdv, cb, ct;
    } obs_t;

    logic clk = 1'b0;
    logic reset, flush, cnt_clear, read_valid;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [31:0] imm, pc, rs1, rs2;
    int total = 0;
    int bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execute_branch_jump_if #(.XLEN(32), .CNT_WIDTH(32)) if0 ();
    execute_branch_jump_if #(.XLEN(32), .CNT_WIDTH(32)) if1 ();
    execute_branch_jump_if #(.XLEN(32), .CNT_WIDTH(2))  if2 ();

    function automatic logic [34:0] alu_calc(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = {31'd0, $signed(a) < $signed(b)};
            5'd3:    r = {31'd0, a < b};
            default: r = '0;
        endcase
        return {r, $signed(a) < $signed(b), a < b, a == b};
    endfunction

    assign {if0.flush, if0.cnt_clear, if0.read_valid, if0.decode_opcode, if0.decode_funct3,
            if0.decode_imm, if0.decode_pc, if0.read_rs1_val, if0.read_rs2_val} =
           {flush, cnt_clear, read_valid, opcode, f3, imm, pc, rs1, rs2};
    assign {if1.flush, if1.cnt_clear, if1.read_valid, if1.decode_opcode, if1.decode_funct3,
            if1.decode_imm, if1.decode_pc, if1.read_rs1_val, if1.read_rs2_val} =
           {flush, cnt_clear, read_valid, opcode, f3, imm, pc, rs1, rs2};
    assign {if2.flush, if2.cnt_clear, if2.read_valid, if2.decode_opcode, if2.decode_funct3,
            if2.decode_imm, if2.decode_pc, if2.read_rs1_val, if2.read_rs2_val} =
           {flush, cnt_clear, read_valid, opcode, f3, imm, pc, rs1, rs2};
    assign {if0.alu_result, if0.alu_lt, if0.alu_ltu, if0.alu_eq} =
           alu_calc(if0.alu_op, if0.in_a[31:0], if0.in_b[31:0]);
    assign {if1.alu_result, if1.alu_lt, if1.alu_ltu, if1.alu_eq} =
           alu_calc(if1.alu_op, if1.in_a[31:0], if1.in_b[31:0]);
    assign {if2.alu_result, if2.alu_lt, if2.alu_ltu, if2.alu_eq} =
           alu_calc(if2.alu_op, if2.in_a[31:0], if2.in_b[31:0]);

    execute_branch_jump #(.XLEN(32), .IALIGN(32), .LOCAL_ADDER(0), .CNT_WIDTH(32)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    execute_branch_jump #(.XLEN(32), .IALIGN(16), .LOCAL_ADDER(1), .CNT_WIDTH(32)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1));
    execute_branch_jump #(.XLEN(32), .IALIGN(32), .LOCAL_ADDER(0), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(if2));

    function automatic obs_t sample(input int d);
        obs_t o;
        case (d)
            0: o = '{if0.valid, if0.jump_pc, if0.rd_write, if0.exception_valid_out,
                     if0.processing, if0.alu_valid, if0.in_a[32] | if0.in_b[32],
                     if0.exception_num_out, if0.pc_out, if0.rd_val, if0.cnt_branches,
                     if0.cnt_taken};
            1: o = '{if1.valid, if1.jump_pc, if1.rd_write, if1.exception_valid_out,
                     if1.processing, if1.alu_valid, if1.in_a[32] | if1.in_b[32],
                     if1.exception_num_out, if1.pc_out, if1.rd_val, if1.cnt_branches,
                     if1.cnt_taken};
            default: o = '{if2.valid, if2.jump_pc, if2.rd_write, if2.exception_valid_out,
                     if2.processing, if2.alu_valid, if2.in_a[32] | if2.in_b[32],
                     if2.exception_num_out, if2.pc_out, if2.rd_val, {30'd0, if2.cnt_branches},
                     {30'd0, if2.cnt_taken}};
        endcase
        return o;
    endfunction

    // Reference behaviour for a recognised instruction.
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f,
                                   input logic [31:0] im, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input int ialign, input int la);
        exp_t e;
        logic br, tk, mis;
        logic [31:0] t;
        br = (o == OpBr);
        case (f)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a < b);
            default: tk = (a >= b);
        endcase
        if (o == OpJalr) t = (a + im) & 32'hFFFF_FFFE;
        else t = p + im;
        mis = (ialign == 32) ? (t[1:0] != 2'b00) : t[0];
        if (!br) tk = 1'b1;
        e.pc_chk = tk;
        e.pco    = t;
        e.jump   = tk && !mis;
        e.exc    = tk && mis;
        e.rd_chk = !br;
        e.rdv    = p + 32'd4;
        e.rdw    = !br && !mis;
        e.lat    = (br && tk && la == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [31:0] im,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        opcode = o; f3 = f; imm = im; pc = p; rs1 = a; rs2 = b; read_valid = 1'b1;
    endtask

    // Issue one instruction, wait (bounded) for completion on instance d, score it.
    task automatic run_one(input int d, input logic [6:0] o, input logic [2:0] f,
                           input logic [31:0] im, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        obs_t s;
        int cyc;
        sb.push_back(model(o, f, im, p, a, b, (d == 1) ? 16 : 32, (d == 1) ? 1 : 0));
        @(posedge clk); #1;
        drive(o, f, im, p, a, b);
        cyc = 0;
        forever begin
            #4;
            s = sample(d);
            if (s.v || cyc >= 3) break;
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        total++;
        if (!s.v) begin
            bad++;
            $display("FAIL timeout d%0d op=%b f3=%0d: valid=0 after %0d cycles, want 1", d, o, f, cyc);
        end else begin
            total++;
            if (cyc !== e.lat) begin bad++; $display("FAIL latency d%0d: got %0d want %0d", d, cyc, e.lat); end
            total++;
            if (s.jp !== e.jump) begin bad++; $display("FAIL jump_pc d%0d: got %b want %b", d, s.jp, e.jump); end
            total++;
            if (s.ex !== e.exc) begin bad++; $display("FAIL exception d%0d: got %b want %b", d, s.ex, e.exc); end
            total++;
            if (s.rw !== e.rdw) begin bad++; $display("FAIL rd_write d%0d: got %b want %b", d, s.rw, e.rdw); end
            total++;
            if (s.ext !== 1'b0) begin bad++; $display("FAIL zero_ext d%0d: got %b want 0", d, s.ext); end
            if (e.pc_chk) begin
                total++;
                if (s.pco !== e.pco) begin bad++; $display("FAIL pc_out d%0d: got %h want %h", d, s.pco, e.pco); end
            end
            if (e.rd_chk) begin
                total++;
                if (s.rdv !== e.rdv) begin bad++; $display("FAIL rd_val d%0d: got %h want %h", d, s.rdv, e.rdv); end
            end
        end
        @(posedge clk); #1;
        read_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t s;
        reset = 1'b1; flush = 1'b0; cnt_clear = 1'b0; read_valid = 1'b0;
        opcode = '0; f3 = '0; imm = '0; pc = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        s = sample(0);
        total++;
        if ({s.v, s.jp, s.rw, s.ex, s.pr, s.av} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", {s.v, s.jp, s.rw, s.ex, s.pr, s.av});
        end
        total++;
        if ({s.en, s.cb, s.ct} !== '0) begin
            bad++; $display("FAIL reset_counters: got en=%0d cb=%0d ct=%0d want 0", s.en, s.cb, s.ct);
        end
        s = sample(2);
        total++;
        if ({s.cb, s.ct} !== '0) begin bad++; $display("FAIL reset_counters_d2: got %0d/%0d want 0/0", s.cb, s.ct); end
    endtask

    task automatic test_branches();
        obs_t s;
        run_one(0, OpBr, 3'd0, 32'h20, 32'h100, 32'd5, 32'd5);
        s = sample(0);
        total++;
        if (s.ct !== 32'd1 || s.cb !== 32'd1) begin
            bad++; $display("FAIL first_counters: got br=%0d tk=%0d want 1/1", s.cb, s.ct);
        end
        run_one(0, OpBr, 3'd4, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1);
        run_one(0, OpBr, 3'd6, 32'h40, 32'h200, 32'hFFFF_FFFF, 32'd1);
        run_one(0, OpBr, 3'd1, 32'h10, 32'h200, 32'd3, 32'd3);
        run_one(0, OpBr, 3'd5, 32'h10, 32'h200, 32'd1, 32'hFFFF_FFFF);
        run_one(0, OpBr, 3'd7, 32'h10, 32'h200, 32'd7, 32'd7);
        run_one(0, OpBr, 3'd0, 32'h22, 32'h100, 32'd5, 32'd5);
        run_one(1, OpBr, 3'd0, 32'h22, 32'h100, 32'd5, 32'd5);
    endtask

    task automatic test_jumps();
        run_one(0, OpJalr, 3'd0, 32'h0, 32'h300, 32'h203, 32'd0);
        run_one(1, OpJalr, 3'd0, 32'h0, 32'h300, 32'h203, 32'd0);
        run_one(0, OpJal, 3'd0, 32'h8, 32'hFFFF_FFFC, 32'd0, 32'd0);
        run_one(0, OpJalr, 3'd0, 32'hFFFF_FFFC, 32'h40, 32'h1000, 32'd0);
        run_one(1, OpJal, 3'd0, 32'h6, 32'h80, 32'd0, 32'd0);
    endtask

    task automatic test_unknown();
        logic [6:0] ops[3] = '{7'b0110011, OpBr, OpJalr};
        logic [2:0] fs[3] = '{3'd0, 3'd2, 3'd1};
        obs_t s0, s1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(ops[i], fs[i], 32'h8, 32'h100, 32'd1, 32'd1);
            #4;
            s0 = sample(0);
            s1 = sample(1);
            total++;
            if ({s0.pr, s0.v, s1.pr, s1.v} !== 4'b0) begin
                bad++; $display("FAIL unknown_%0d: got pr/v=%b want 0000", i, {s0.pr, s0.v, s1.pr, s1.v});
            end
        end
        @(posedge clk); #1 read_valid = 1'b0;
    endtask

    task automatic test_flush();
        obs_t s, s_pre;
        s_pre = sample(0);
        @(posedge clk); #1;
        drive(OpBr, 3'd1, 32'h10, 32'h400, 32'd1, 32'd2);
        #4 s = sample(0);
        total++;
        if ({s.pr, s.v} !== 2'b10) begin bad++; $display("FAIL taken_cycle0: got pr/v=%b want 10", {s.pr, s.v}); end
        @(posedge clk); #1 flush = 1'b1;
        #4 s = sample(0);
        total++;
        if ({s.v, s.jp, s.rw, s.ex} !== 4'b0) begin
            bad++; $display("FAIL flush_target: got %b want 0000", {s.v, s.jp, s.rw, s.ex});
        end
        @(posedge clk); #1 flush = 1'b0; read_valid = 1'b0;
        #4 s = sample(0);
        total++;
        if (s.pr !== 1'b0) begin bad++; $display("FAIL flush_state: processing=%b want 0", s.pr); end
        total++;
        if (s.cb !== s_pre.cb || s.ct !== s_pre.ct) begin
            bad++; $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", s.cb, s.ct, s_pre.cb, s_pre.ct);
        end
        @(posedge clk); #1;
        drive(OpJal, 3'd0, 32'h8, 32'h400, 32'd0, 32'd0);
        flush = 1'b1;
        #4 s = sample(0);
        total++;
        if ({s.v, s.jp, s.rw, s.ex} !== 4'b0) begin
            bad++; $display("FAIL flush_jal: got %b want 0000", {s.v, s.jp, s.rw, s.ex});
        end
        @(posedge clk); #1;
        drive(OpBr, 3'd0, 32'h8, 32'h400, 32'd4, 32'd4);
        @(posedge clk); #1 flush = 1'b0; read_valid = 1'b0;
        #4 s = sample(0);
        total++;
        if (s.pr !== 1'b0) begin bad++; $display("FAIL flush_check_blocks: processing=%b want 0", s.pr); end
        run_one(1, OpBr, 3'd1, 32'h10, 32'h400, 32'd1, 32'd2);
    endtask

    task automatic test_reset_mid_target();
        obs_t s;
        @(posedge clk); #1;
        drive(OpBr, 3'd0, 32'h10, 32'h600, 32'd9, 32'd9);
        @(posedge clk); #1 reset = 1'b1;
        #4 s = sample(0);
        total++;
        if (s.v !== 1'b0) begin bad++; $display("FAIL reset_target_valid: got %b want 0", s.v); end
        @(posedge clk); #1 reset = 1'b0; read_valid = 1'b0;
        #4 s = sample(0);
        total++;
        if ({s.pr, s.cb[0], s.ct[0]} !== 3'b0) begin
            bad++; $display("FAIL reset_target_state: got %b want 000", {s.pr, s.cb[0], s.ct[0]});
        end
    endtask

    task automatic test_counters();
        obs_t s;
        @(posedge clk); #1 cnt_clear = 1'b1;
        @(posedge clk); #1 cnt_clear = 1'b0;
        for (int i = 0; i < 4; i++) run_one(2, OpBr, 3'd0, 32'h8, 32'h500, 32'd5, 32'd5);
        s = sample(2);
        total++;
        if (s.ct !== 32'd3 || s.cb !== 32'd3) begin
            bad++; $display("FAIL saturate: got br=%0d tk=%0d want 3/3", s.cb, s.ct);
        end
        @(posedge clk); #1;
        drive(OpBr, 3'd1, 32'h8, 32'h500, 32'd1, 32'd1);
        cnt_clear = 1'b1;
        #4 s = sample(2);
        total++;
        if (s.v !== 1'b1) begin bad++; $display("FAIL clear_branch_valid: got %b want 1", s.v); end
        @(posedge clk); #1 cnt_clear = 1'b0; read_valid = 1'b0;
        #4 s = sample(2);
        total++;
        if (s.cb !== 32'd0 || s.ct !== 32'd0) begin
            bad++; $display("FAIL clear_wins: got br=%0d tk=%0d want 0/0", s.cb, s.ct);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] brf[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        int k;
        logic [31:0] a, b, im;
        for (int i = 0; i < 12; i++) begin
            k  = $urandom_range(0, 7);
            a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            im = {22'd0, 8'($urandom_range(0, 255)), 2'b00} + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            if (k < 6) run_one(i % 2, OpBr, brf[k], im, 32'h1000 + 32'(i * 4), a, b);
            else if (k == 6) run_one(i % 2, OpJal, 3'd0, im, 32'h2000, a, b);
            else run_one(i % 2, OpJalr, 3'd0, im, 32'h3000, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_jumps();
        test_unknown();
        test_flush();
        test_reset_mid_target();
        test_counters();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "global timeout");
    end
endmodule
